// File: rtl/reset_sequencer.sv
// Power-on / re-sequence reset generator: holds all channels, releases them one by one,
// then services debounced full re-sequence requests and per-channel soft resets.
module reset_sequencer #(
  parameter int unsigned N_CH            = 2,
  parameter int unsigned HOLD_CYCLES     = 32,
  parameter int unsigned STAGGER_CYCLES  = 8,
  parameter logic        RESET_LEVEL     = 1'b0,
  parameter int unsigned DEBOUNCE_CYCLES = 4
) (
  input  logic            CLK100MHZ,
  input  logic            fpga_rst,
  input  logic            mcu_rst_req,
  input  logic [N_CH-1:0] ch_rst_req,
  output logic [N_CH-1:0] rst_out,
  output logic            seq_done,
  output logic            busy
);

  localparam int unsigned CntMax = (HOLD_CYCLES > STAGGER_CYCLES) ? HOLD_CYCLES : STAGGER_CYCLES;
  localparam int unsigned CntW   = $clog2(CntMax + 1);
  localparam int unsigned HoldW  = $clog2(HOLD_CYCLES + 1);
  localparam int unsigned DebW   = $clog2(DEBOUNCE_CYCLES + 1);

  localparam logic [CntW-1:0]  CntSat   = CntW'(CntMax);
  localparam logic [CntW-1:0]  HoldLast = CntW'(HOLD_CYCLES - 1);
  localparam logic [CntW-1:0]  StagLast = CntW'(STAGGER_CYCLES - 1);
  localparam logic [HoldW-1:0] HoldLoad = HoldW'(HOLD_CYCLES);
  localparam logic [DebW-1:0]  DebSat   = DebW'(DEBOUNCE_CYCLES);
  localparam logic [DebW-1:0]  DebLast  = DebW'(DEBOUNCE_CYCLES - 1);

  typedef enum logic [1:0] {StAssert, StHold, StStagger, StDone} state_e;

  state_e           r_state, w_state_d;
  logic [CntW-1:0]  r_cnt, w_cnt_d, w_cnt_inc;
  logic [N_CH-1:0]  r_released, w_rel_d, w_rel_shift;
  logic [N_CH-1:0]  r_rst_out;
  logic [HoldW-1:0] r_hold   [N_CH];
  logic [HoldW-1:0] w_hold_d [N_CH];
  logic [N_CH-1:0]  w_hold_busy;
  logic             r_rst_sync;
  logic [1:0]       r_mcu_sync;
  logic             w_mcu;
  logic [DebW-1:0]  r_deb, w_deb_d;
  logic             r_fire;
  logic             r_seq_done, w_seq_done_d;
  logic             r_busy;
  logic             w_release;

  assign w_mcu = r_mcu_sync[1];

  always_comb begin
    w_deb_d = '0;
    if (w_mcu) begin
      w_deb_d = (r_deb == DebSat) ? r_deb : r_deb + DebW'(1);
    end
  end

  always_comb begin
    w_state_d    = r_state;
    w_cnt_d      = r_cnt;
    w_rel_d      = r_released;
    w_seq_done_d = r_seq_done;
    w_release    = 1'b0;
    w_cnt_inc    = (r_cnt == CntSat) ? r_cnt : r_cnt + CntW'(1);
    // Thermometer: the next channel to release is the one above the highest released.
    w_rel_shift    = '0;
    w_rel_shift[0] = 1'b1;
    for (int k = 1; k < N_CH; k++) begin
      w_rel_shift[k] = r_released[k-1];
    end
    for (int k = 0; k < N_CH; k++) begin
      w_hold_busy[k] = (r_hold[k] != '0);
      w_hold_d[k]    = w_hold_busy[k] ? r_hold[k] - HoldW'(1) : '0;
    end

    case (r_state)
      StAssert: begin
        // The ASSERT state itself is the second stage of the deassert synchroniser.
        if (r_rst_sync) begin
          w_state_d = StHold;
          w_cnt_d   = '0;
        end
      end
      StHold: begin
        if (w_mcu) begin
          w_cnt_d = '0;
        end else if (r_cnt == HoldLast) begin
          w_release = 1'b1;
        end else begin
          w_cnt_d = w_cnt_inc;
        end
      end
      StStagger: begin
        if (r_cnt == StagLast) begin
          w_release = 1'b1;
        end else begin
          w_cnt_d = w_cnt_inc;
        end
      end
      StDone: begin
        for (int k = 0; k < N_CH; k++) begin
          if (ch_rst_req[k]) begin
            w_hold_d[k] = HoldLoad;
          end
        end
      end
      default: w_state_d = StAssert;
    endcase

    if (w_release) begin
      w_rel_d      = w_rel_shift;
      w_cnt_d      = '0;
      w_state_d    = w_rel_shift[N_CH-1] ? StDone : StStagger;
      w_seq_done_d = w_rel_shift[N_CH-1];
    end

    // Debounced re-sequence overrides everything, including same-cycle channel requests.
    if (r_fire) begin
      w_state_d    = StHold;
      w_cnt_d      = '0;
      w_rel_d      = '0;
      w_seq_done_d = 1'b0;
      for (int k = 0; k < N_CH; k++) begin
        w_hold_d[k] = '0;
      end
    end
  end

  always_ff @(posedge CLK100MHZ or posedge fpga_rst) begin
    if (fpga_rst) begin
      r_state    <= StAssert;
      r_cnt      <= '0;
      r_released <= '0;
      r_rst_sync <= 1'b0;
      r_mcu_sync <= '0;
      r_deb      <= '0;
      r_fire     <= 1'b0;
      r_seq_done <= 1'b0;
      r_busy     <= 1'b1;
      r_rst_out  <= {N_CH{RESET_LEVEL}};
      for (int k = 0; k < N_CH; k++) begin
        r_hold[k] <= '0;
      end
    end else begin
      r_rst_sync <= 1'b1;
      r_mcu_sync <= {r_mcu_sync[0], mcu_rst_req};
      r_deb      <= w_deb_d;
      r_fire     <= w_mcu && (r_deb == DebLast);
      r_state    <= w_state_d;
      r_cnt      <= w_cnt_d;
      r_released <= w_rel_d;
      r_seq_done <= w_seq_done_d;
      r_busy     <= (r_state != StDone) || (|w_hold_busy);
      for (int k = 0; k < N_CH; k++) begin
        r_hold[k]    <= w_hold_d[k];
        r_rst_out[k] <= (w_rel_d[k] && (w_hold_d[k] == '0)) ? ~RESET_LEVEL : RESET_LEVEL;
      end
    end
  end

  assign rst_out  = r_rst_out;
  assign seq_done = r_seq_done;
  assign busy     = r_busy;

endmodule

// File: tb/tb_reset_sequencer.sv
// Bench for reset_sequencer: event-time reference model (release/hold end edges) driven by
// directed and random stimulus, plus a directed check of a fast 4-channel configuration.
module tb_reset_sequencer;

  localparam int unsigned N = 2;
  localparam int unsigned H = 32;
  localparam int unsigned S = 8;
  localparam int unsigned D = 4;
  localparam logic        RL = 1'b0;
  localparam int          INF = 1_000_000_000;

  logic         clk = 1'b0;
  logic         fpga_rst = 1'b0;
  logic         mcu_rst_req = 1'b0;
  logic [N-1:0] ch_rst_req = '0;
  logic [N-1:0] rst_out;
  logic         seq_done, busy;

  logic         fpga_rst4 = 1'b0;
  logic         mcu4 = 1'b0;
  logic [3:0]   ch4 = '0;
  logic [3:0]   rst_out4;
  logic         seq_done4, busy4;

  always #5 clk = ~clk;

  reset_sequencer #(
    .N_CH(N), .HOLD_CYCLES(H), .STAGGER_CYCLES(S), .RESET_LEVEL(RL), .DEBOUNCE_CYCLES(D)
  ) dut (
    .CLK100MHZ(clk), .fpga_rst(fpga_rst), .mcu_rst_req(mcu_rst_req), .ch_rst_req(ch_rst_req),
    .rst_out(rst_out), .seq_done(seq_done), .busy(busy)
  );

  reset_sequencer #(
    .N_CH(4), .HOLD_CYCLES(1), .STAGGER_CYCLES(1), .RESET_LEVEL(1'b0), .DEBOUNCE_CYCLES(4)
  ) dut4 (
    .CLK100MHZ(clk), .fpga_rst(fpga_rst4), .mcu_rst_req(mcu4), .ch_rst_req(ch4),
    .rst_out(rst_out4), .seq_done(seq_done4), .busy(busy4)
  );

  int checks = 0;
  int failures = 0;
  int n = 0;
  int e1 = 0;
  int j;
  // Model: per-channel edge of sequence release and edge after which a soft hold ends.
  int rel [N];
  int hold_end [N];
  int done_edge;
  bit in_reset, cur_prev, fired;
  int run_len, fire_at, end_b;

  task automatic check(string tag, logic [15:0] obs, logic [15:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s at edge %0d: observed %h expected %h", tag, n, obs, exp);
    end
  endtask

  task automatic model_reset();
    in_reset  = 1'b1;
    cur_prev  = 1'b1;
    fired     = 1'b0;
    done_edge = INF;
    run_len   = 0;
    fire_at   = INF;
    end_b     = INF;
    for (int k = 0; k < N; k++) begin
      rel[k]      = INF;
      hold_end[k] = 0;
    end
  endtask

  task automatic compare(bit exp_busy);
    logic [N-1:0] exp_rst;
    for (int k = 0; k < N; k++) begin
      exp_rst[k] = (n < rel[k] || n < hold_end[k]) ? RL : ~RL;
    end
    check("rst_out", 16'(rst_out), 16'(exp_rst));
    check("seq_done", 16'(seq_done), 16'(n >= done_edge));
    check("busy", 16'(busy), 16'(exp_busy));
  endtask

  task automatic tick();
    bit accept, cur, exp_busy;
    int c;
    @(posedge clk);
    n++;
    if (!fpga_rst) begin
      if (in_reset) begin
        in_reset = 1'b0;
        e1 = n;
        for (int k = 0; k < N; k++) rel[k] = n + 1 + int'(H) + k * int'(S);
        done_edge = rel[N-1];
      end
      accept = (n - 1 >= done_edge) && (n != fire_at);
      if (mcu_rst_req) begin
        run_len++;
        if (run_len == int'(D)) begin
          fire_at = n + 3;
          end_b   = INF;
        end
      end else if (run_len > 0) begin
        if (run_len >= int'(D)) end_b = n - 1;
        run_len = 0;
      end
      if (n == fire_at) begin
        fired = 1'b1;
        done_edge = INF;
        for (int k = 0; k < N; k++) begin
          rel[k]      = INF;
          hold_end[k] = 0;
        end
      end
      // HOLD counting begins at the first low synchronised sample after the fire edge.
      if (fired && end_b != INF) begin
        c = (end_b + 3 > fire_at + 1) ? end_b + 3 : fire_at + 1;
        for (int k = 0; k < N; k++) rel[k] = c + int'(H) - 1 + k * int'(S);
        done_edge = rel[N-1];
        fired = 1'b0;
      end
      if (accept) begin
        for (int k = 0; k < N; k++) if (ch_rst_req[k]) hold_end[k] = n + int'(H);
      end
    end
    #1;
    exp_busy = cur_prev;
    cur = in_reset || (n < done_edge);
    for (int k = 0; k < N; k++) cur = cur || (n < hold_end[k]);
    cur_prev = cur;
    compare(exp_busy);
  endtask

  task automatic run(int cycles);
    ch_rst_req = '0;
    for (int i = 0; i < cycles; i++) tick();
  endtask

  task automatic pulse_ch(logic [N-1:0] m);
    ch_rst_req = m;
    tick();
    ch_rst_req = '0;
  endtask

  initial begin
    int kind, len, pick, g;
    logic [N-1:0] m;
    logic [3:0] exp4;
    model_reset();
    #1 fpga_rst = 1'b1;
    fpga_rst4 = 1'b1;
    #1 compare(1'b1);
    tick();
    tick();
    fpga_rst = 1'b0;
    fpga_rst4 = 1'b0;

    // Power-up sequence; the fast 4-channel instance is checked against edges E1..E8.
    for (int i = 0; i < 50; i++) begin
      tick();
      j = n - e1 + 1;
      if (j >= 1 && j <= 8) begin
        for (int k = 0; k < 4; k++) exp4[k] = (j >= 3 + k);
        check("rst_out4", 16'(rst_out4), 16'(exp4));
        check("seq_done4", 16'(seq_done4), 16'(j >= 6));
        check("busy4", 16'(busy4), 16'(j < 7));
      end
    end

    // Short request ignored, long request re-sequences.
    mcu_rst_req = 1'b1;
    repeat (3) tick();
    mcu_rst_req = 1'b0;
    run(20);
    mcu_rst_req = 1'b1;
    repeat (6) tick();
    mcu_rst_req = 1'b0;
    run(60);

    // Single soft reset, then a restarted one.
    pulse_ch(2'b01);
    run(40);
    pulse_ch(2'b01);
    run(9);
    pulse_ch(2'b01);
    run(50);

    // Abort at E20 of a fresh sequence, with channel requests landing in HOLD.
    fpga_rst = 1'b1;
    #1 model_reset();
    compare(1'b1);
    tick();
    fpga_rst = 1'b0;
    for (int i = 0; i < 20; i++) begin
      ch_rst_req = (i == 10) ? 2'b11 : 2'b00;
      tick();
    end
    ch_rst_req = '0;
    #2 fpga_rst = 1'b1;
    #1 model_reset();
    compare(1'b1);
    tick();
    tick();
    fpga_rst = 1'b0;
    run(50);

    for (int it = 0; it < 16; it++) begin
      g = 0;
      while (n < done_edge && g < 300) begin
        tick();
        g++;
      end
      kind = int'($urandom_range(0, 3));
      len  = int'($urandom_range(1, 8));
      m    = N'($urandom_range(1, 3));
      case (kind)
        0: begin
          mcu_rst_req = 1'b1;
          repeat (len) tick();
          mcu_rst_req = 1'b0;
          tick();
        end
        1: begin
          pulse_ch(m);
          run(int'($urandom_range(0, 40)));
        end
        2: begin
          pulse_ch(m);
          run(int'($urandom_range(0, 30)));
          pulse_ch(m);
        end
        default: begin
          pick = int'($urandom_range(0, 7));
          mcu_rst_req = 1'b1;
          for (int i = 0; i < len; i++) begin
            ch_rst_req = (i == pick) ? m : '0;
            tick();
          end
          mcu_rst_req = 1'b0;
          ch_rst_req = '0;
          tick();
        end
      endcase
      run(int'($urandom_range(1, 10)));
    end
    run(120);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/reset_sequencer.md
RESET_SEQUENCER -- requirements
Module: reset_sequencer

Interface
REQ-001 Parameter N_CH, default 2: number of reset output channels, legal 1..16.
REQ-002 Parameter HOLD_CYCLES, default 32: cycles all channels stay asserted after the sequence starts, legal >=1.
REQ-003 Parameter STAGGER_CYCLES, default 8: cycles between successive channel releases, legal >=1.
REQ-004 Parameter RESET_LEVEL, default 1'b0: asserted level of every rst_out bit.
REQ-005 Parameter DEBOUNCE_CYCLES, default 4: consecutive synchronised-high cycles needed on mcu_rst_req, legal >=1.
REQ-006 CLK100MHZ  input  1  sole clock, all logic on rising edge.
REQ-007 fpga_rst  input  1  asynchronous, active-high block reset.
REQ-008 mcu_rst_req  input  1  asynchronous level request for a full re-sequence (button/external).
REQ-009 ch_rst_req  input  N_CH  synchronous one-cycle pulses, per-channel soft reset request.
REQ-010 rst_out  output  N_CH  channel resets; bit k is RESET_LEVEL while channel k is held in reset.
REQ-011 seq_done  output  1  high once all channels have been released by the sequence.
REQ-012 busy  output  1  high while the sequence runs or any per-channel hold is active.

Function
REQ-013 States: ASSERT, HOLD, STAGGER, DONE; the FSM shall be one-hot or binary at implementer's choice.
REQ-014 ASSERT: all channels asserted; lasts exactly 2 rising edges after fpga_rst falls (deassert synchroniser), then HOLD.
REQ-015 HOLD: cycle counter runs HOLD_CYCLES cycles, all channels asserted; on expiry rst_out[0] releases and FSM goes to STAGGER (DONE if N_CH==1).
REQ-016 STAGGER: channel k releases STAGGER_CYCLES cycles after channel k-1; DONE is entered on the same edge that releases channel N_CH-1.
REQ-017 Timing: with E1 the first rising edge seeing fpga_rst low, rst_out[k] shall change to ~RESET_LEVEL after edge E(2+HOLD_CYCLES+k*STAGGER_CYCLES).
REQ-018 seq_done shall rise on the same edge as the final channel release and stay high until a re-sequence or fpga_rst.
REQ-019 mcu_rst_req shall pass a 2-flop synchroniser; after DEBOUNCE_CYCLES consecutive high synchronised samples, on the next edge all channels assert, seq_done clears, per-channel holds clear, FSM enters HOLD with counter 0.
REQ-020 While synchronised mcu_rst_req stays high, HOLD counter shall be held at 0; counting starts on the first low sample.
REQ-021 Synchronised mcu_rst_req high runs shorter than DEBOUNCE_CYCLES shall have no effect; debounce counter resets on any low sample.
REQ-022 ch_rst_req[k] in DONE: rst_out[k] asserts next edge for exactly HOLD_CYCLES cycles, then releases; seq_done unaffected.
REQ-023 ch_rst_req bits shall be ignored outside DONE.
REQ-024 Channels shall time independently; simultaneous requests each start their own hold on the same edge.
REQ-025 A ch_rst_req[k] during an active hold on channel k shall restart that channel's counter at HOLD_CYCLES.
REQ-026 A debounced mcu_rst_req shall take priority over any same-cycle ch_rst_req.
REQ-027 busy = (state != DONE) OR any per-channel hold active, registered.
REQ-028 Counter widths shall be $clog2(max count + 1); counters shall saturate, never wrap.

Reset
REQ-029 While fpga_rst is high: state ASSERT, rst_out all RESET_LEVEL, seq_done 0, busy 1, all counters and synchronisers 0, independent of clock.
REQ-030 fpga_rst asserting mid-sequence or mid-hold shall abort immediately to the REQ-029 values.

Verification
REQ-031 Defaults, fpga_rst high 2 cycles then low -> rst_out[0] releases after edge E34, rst_out[1] after E42, seq_done rises at E42, busy falls at E43.
REQ-032 In DONE, mcu_rst_req high 3 cycles -> no change; high 6 cycles -> all rst_out assert 7 cycles after first high sample (2 sync + 4 debounce + 1), then full re-sequence with the same 32/8 spacing measured from the first low sample.
REQ-033 In DONE, ch_rst_req=2'b01 one cycle -> rst_out[0] low for exactly 32 cycles, rst_out[1] and seq_done unchanged, busy high for the same 32 cycles.
REQ-034 ch_rst_req[0] pulse, then again 10 cycles later -> rst_out[0] low for 42 cycles total; ch_rst_req during HOLD -> ignored.
REQ-035 fpga_rst pulsed at E20 of a sequence -> all outputs return to reset values asynchronously; a fresh sequence times from the new release.
REQ-036 N_CH=4, STAGGER_CYCLES=1, HOLD_CYCLES=1 -> releases on consecutive edges E3..E6, seq_done at E6.
